// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, instruction formats,
// per-format operand field widths and the opcode-to-format decode.
package inst_pkg;

  localparam int INST_W = 9;

  localparam logic [3:0] OP_ALU0 = 4'b0000;
  localparam logic [3:0] OP_ALU1 = 4'b0001;
  localparam logic [3:0] OP_ALU2 = 4'b0010;
  localparam logic [3:0] OP_ALU3 = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ST   = 4'b0110;
  localparam logic [3:0] OP_LD   = 4'b0111;
  localparam logic [3:0] OP_BR   = 4'b1000;
  localparam logic [3:0] OP_JMP  = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1010;
  localparam logic [3:0] OP_RSVD = 4'b1011;
  localparam logic [3:0] OP_ALU4 = 4'b1100;
  localparam logic [3:0] OP_ADDI = 4'b1101;
  localparam logic [3:0] OP_ANDI = 4'b1110;
  localparam logic [3:0] OP_CLR  = 4'b1111;

  typedef enum logic [2:0] {FMT_R, FMT_SHCMP, FMT_LDST, FMT_IMM5, FMT_CLR, FMT_ILL} fmt_t;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} enc_state_t;

  localparam int R_REG_W   = 5;
  localparam int R_IMM_W   = 0;
  localparam int SH_REG_W  = 2;
  localparam int SH_IMM_W  = 3;
  localparam int LS_REG_W  = 3;
  localparam int LS_IMM_W  = 2;
  localparam int I5_REG_W  = 0;
  localparam int I5_IMM_W  = 5;
  localparam int CLR_REG_W = 5;
  localparam int CLR_IMM_W = 0;

  function automatic fmt_t op_fmt(input logic [3:0] op);
    fmt_t f;
    f = FMT_ILL;
    case (op)
      OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3, OP_ALU4: f = FMT_R;
      OP_SHL, OP_SHR, OP_CMP:                      f = FMT_SHCMP;
      OP_ST, OP_LD:                                f = FMT_LDST;
      OP_BR, OP_JMP, OP_ADDI, OP_ANDI:             f = FMT_IMM5;
      OP_CLR:                                      f = FMT_CLR;
      default:                                     f = FMT_ILL;
    endcase
    return f;
  endfunction

  function automatic int fmt_reg_w(input fmt_t f);
    case (f)
      FMT_R:     return R_REG_W;
      FMT_SHCMP: return SH_REG_W;
      FMT_LDST:  return LS_REG_W;
      FMT_IMM5:  return I5_REG_W;
      FMT_CLR:   return CLR_REG_W;
      default:   return 5;
    endcase
  endfunction

  function automatic int fmt_imm_w(input fmt_t f);
    case (f)
      FMT_R:     return R_IMM_W;
      FMT_SHCMP: return SH_IMM_W;
      FMT_LDST:  return LS_IMM_W;
      FMT_IMM5:  return I5_IMM_W;
      FMT_CLR:   return CLR_IMM_W;
      default:   return 5;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Loader request handshake and instruction-memory write port of the encoder.
interface inst_encoder_if #(parameter int ADDR_W = 9);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_opcode;
  logic [4:0]        req_reg;
  logic [4:0]        req_imm;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [8:0]        im_wdata;

  modport master (output req_valid, req_opcode, req_reg, req_imm,
                  input  req_ready, im_we, im_addr, im_wdata);
  modport slave  (input  req_valid, req_opcode, req_reg, req_imm,
                  output req_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational packer: {opcode, reg, imm} -> 9-bit instruction word plus illegal flag.
// Define INST_ENC_RANGE_CHECK_EN to flag operands with bits outside their format's fields.
module inst_pack
  import inst_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic [4:0]        reg_val,
  input  logic [4:0]        imm_val,
  output logic [INST_W-1:0] word,
  output logic              illegal
);

  fmt_t       fmt;
  logic [4:0] low;
  logic       over;

  always_comb begin
    fmt = op_fmt(opcode);
    low = '0;
    case (fmt)
      FMT_R, FMT_CLR: low = reg_val;
      FMT_SHCMP:      low = {reg_val[1:0], imm_val[2:0]};
      FMT_LDST:       low = {reg_val[2:0], imm_val[1:0]};
      FMT_IMM5:       low = imm_val;
      default:        low = '0;
    endcase
`ifdef INST_ENC_RANGE_CHECK_EN
    over = ((reg_val >> fmt_reg_w(fmt)) != 5'd0) || ((imm_val >> fmt_imm_w(fmt)) != 5'd0);
`else
    over = 1'b0;
`endif
    word    = {opcode, low};
    illegal = (fmt == FMT_ILL) || over;
  end

endmodule

// File: rtl/inst_encoder.sv
// Session FSM, write stage and error status streaming packed instructions into
// consecutive instruction-memory addresses. Range checking: INST_ENC_RANGE_CHECK_EN.
module inst_encoder
  import inst_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 9
)(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  inst_encoder_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt
);

  enc_state_t        state, state_nxt;
  logic [INST_W-1:0] word_p0;
  logic              illegal_p0;
  logic              ready, accept_p0, wr_p0, bad_p0, done_nxt;
  logic [LEN_W-1:0]  remain;
  logic [ADDR_W-1:0] addr_next;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [8:0]        data_p1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  inst_pack u_pack (
    .opcode  (bus.req_opcode),
    .reg_val (bus.req_reg),
    .imm_val (bus.req_imm),
    .word    (word_p0),
    .illegal (illegal_p0)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && length != '0) state_nxt = LOAD;
        if (start && length == '0) done_nxt  = 1'b1;
      end
      LOAD: begin
        ready = !abort;
        if (abort)
          state_nxt = IDLE;
        else if (bus.req_valid && !illegal_p0 && remain == LEN_W'(1))
          state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && state_nxt == IDLE) done_nxt = 1'b1;
    accept_p0 = ready && bus.req_valid;
    wr_p0     = accept_p0 && !illegal_p0;
    bad_p0    = accept_p0 && illegal_p0;
  end

  // p0 -> p1: accepted legal request enters the one-entry write stage
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      remain    <= '0;
      addr_next <= '0;
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      data_p1   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      done   <= done_nxt;
      vld_p1 <= wr_p0;
      if (state == IDLE && start) begin
        remain    <= length;
        addr_next <= base_addr;
        err       <= 1'b0;
        err_cnt   <= '0;
      end
      if (wr_p0) begin
        addr_p1   <= addr_next;
        data_p1   <= word_p0;
        addr_next <= addr_next + ADDR_W'(1);
        remain    <= remain - LEN_W'(1);
      end
      if (bad_p0) begin
        err     <= 1'b1;
        err_cnt <= sat_inc8(err_cnt);
      end
    end
  end

  assign busy          = (state != IDLE);
  assign bus.req_ready = ready;
  assign bus.im_we     = vld_p1;
  assign bus.im_addr   = addr_p1;
  assign bus.im_wdata  = data_p1;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: packing, sessions, illegal requests, wrap, abort and reset.
module tb_inst_encoder;

  logic       Clk = 1'b0;
  logic       Reset_n, start, abort;
  logic [8:0] base_addr, length;
  logic       busy, done, err;
  logic [7:0] err_cnt;
  int         vec_cnt = 0;
  int         miss_cnt = 0;

  always #5 Clk = ~Clk;

  inst_encoder_if #(.ADDR_W(9)) bus ();

  inst_encoder #(.ADDR_W(9), .LEN_W(9)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] r, input logic [4:0] i);
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_reg    = r;
    bus.req_imm    = i;
  endtask

  task automatic quiet();
    bus.req_valid  = 1'b0;
    bus.req_opcode = 4'h0;
    bus.req_reg    = 5'h0;
    bus.req_imm    = 5'h0;
  endtask

  task automatic begin_session(input logic [8:0] b, input logic [8:0] l);
    start = 1'b1; base_addr = b; length = l;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [30:0] g;
    Reset_n = 1'b0;
    tick(); tick();
    g = {busy, done, err, err_cnt, bus.req_ready, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== 31'd0) begin
      miss_cnt++; $display("FAIL reset_outputs: got %h want 0", g);
    end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_len0();
    logic [2:0] g;
    begin_session(9'h005, 9'd0);
    g = {done, busy, bus.im_we};
    vec_cnt++;
    if (g !== 3'b100) begin miss_cnt++; $display("FAIL len0_done: got %b want 100", g); end
    tick();
    g = {done, busy, bus.im_we};
    vec_cnt++;
    if (g !== 3'b000) begin miss_cnt++; $display("FAIL len0_after: got %b want 000", g); end
  endtask

  task automatic test_basic();
    logic [19:0] g;
    logic [2:0]  s;
    begin_session(9'h010, 9'd3);
    s = {busy, bus.req_ready, err};
    vec_cnt++;
    if (s !== 3'b110) begin miss_cnt++; $display("FAIL basic_load: got %b want 110", s); end
    send(4'b1101, 5'd0, 5'd5); tick();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b0, 1'b1, 9'h010, 9'h1A5}) begin miss_cnt++; $display("FAIL basic_w0: got %h want %h", g, {1'b0, 1'b1, 9'h010, 9'h1A5}); end
    send(4'b0010, 5'd17, 5'd0); tick();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b0, 1'b1, 9'h011, 9'h051}) begin miss_cnt++; $display("FAIL basic_w1: got %h want %h", g, {1'b0, 1'b1, 9'h011, 9'h051}); end
    send(4'b1111, 5'd16, 5'd0); tick();
    quiet();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    s = {busy, bus.req_ready, done};
    vec_cnt++;
    if (g !== {1'b0, 1'b1, 9'h012, 9'h1F0} || s !== 3'b100) begin
      miss_cnt++; $display("FAIL basic_w2: got %h/%b want %h/100", g, s, {1'b0, 1'b1, 9'h012, 9'h1F0});
    end
    tick();
    s = {done, busy, bus.im_we};
    vec_cnt++;
    if (s !== 3'b100) begin miss_cnt++; $display("FAIL basic_done: got %b want 100", s); end
    tick();
    vec_cnt++;
    if (done !== 1'b0) begin miss_cnt++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_ldshift();
    logic [19:0] g;
    begin_session(9'h020, 9'd2);
    send(4'b0111, 5'd5, 5'd2); tick();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b0, 1'b1, 9'h020, 9'h0F6}) begin miss_cnt++; $display("FAIL ld_word: got %h want %h", g, {1'b0, 1'b1, 9'h020, 9'h0F6}); end
    send(4'b0100, 5'd2, 5'd7); tick();
    quiet();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b0, 1'b1, 9'h021, 9'h097}) begin miss_cnt++; $display("FAIL shl_word: got %h want %h", g, {1'b0, 1'b1, 9'h021, 9'h097}); end
    tick();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b1, 1'b0, 9'h021, 9'h097}) begin miss_cnt++; $display("FAIL ldshift_hold: got %h want %h", g, {1'b1, 1'b0, 9'h021, 9'h097}); end
    tick();
  endtask

  task automatic test_illegal();
    logic [19:0] g;
    logic [11:0] s;
    begin_session(9'h030, 9'd2);
    send(4'b1011, 5'd0, 5'd0); tick();
    s = {bus.im_we, err, err_cnt, busy, bus.req_ready};
    vec_cnt++;
    if (s !== {1'b0, 1'b1, 8'd1, 1'b1, 1'b1}) begin miss_cnt++; $display("FAIL illegal_status: got %h want %h", s, {1'b0, 1'b1, 8'd1, 1'b1, 1'b1}); end
    send(4'b1101, 5'd0, 5'd1); tick();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b0, 1'b1, 9'h030, 9'h1A1}) begin miss_cnt++; $display("FAIL illegal_w0: got %h want %h", g, {1'b0, 1'b1, 9'h030, 9'h1A1}); end
    send(4'b1101, 5'd0, 5'd2); tick();
    quiet();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b0, 1'b1, 9'h031, 9'h1A2}) begin miss_cnt++; $display("FAIL illegal_w1: got %h want %h", g, {1'b0, 1'b1, 9'h031, 9'h1A2}); end
    tick();
    s = {bus.im_we, err, err_cnt, busy, done};
    vec_cnt++;
    if (s !== {1'b0, 1'b1, 8'd1, 1'b0, 1'b1}) begin miss_cnt++; $display("FAIL illegal_done: got %h want %h", s, {1'b0, 1'b1, 8'd1, 1'b0, 1'b1}); end
    tick();
  endtask

  task automatic test_range();
    logic [19:0] g;
    logic [8:0]  s;
    begin_session(9'h040, 9'd1);
    s = {err, err_cnt};
    vec_cnt++;
    if (s !== 9'd0) begin miss_cnt++; $display("FAIL err_clear_on_start: got %h want 0", s); end
    send(4'b0111, 5'd9, 5'd2); tick();
`ifdef INST_ENC_RANGE_CHECK_EN
    s = {bus.im_we, err, err_cnt[6:0]};
    vec_cnt++;
    if (s !== {1'b0, 1'b1, 7'd1}) begin miss_cnt++; $display("FAIL range_illegal: got %h want %h", s, {1'b0, 1'b1, 7'd1}); end
    send(4'b0111, 5'd1, 5'd2); tick();
`endif
    quiet();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b0, 1'b1, 9'h040, 9'h0E6}) begin miss_cnt++; $display("FAIL range_word: got %h want %h", g, {1'b0, 1'b1, 9'h040, 9'h0E6}); end
    tick();
    vec_cnt++;
    if ({done, busy} !== 2'b10) begin miss_cnt++; $display("FAIL range_done: got %b want 10", {done, busy}); end
    tick();
  endtask

  task automatic test_wrap();
    logic [19:0] g;
    begin_session(9'h1FF, 9'd2);
    send(4'b1101, 5'd0, 5'd3); tick();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b0, 1'b1, 9'h1FF, 9'h1A3}) begin miss_cnt++; $display("FAIL wrap_w0: got %h want %h", g, {1'b0, 1'b1, 9'h1FF, 9'h1A3}); end
    send(4'b1101, 5'd0, 5'd4); tick();
    quiet();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b0, 1'b1, 9'h000, 9'h1A4}) begin miss_cnt++; $display("FAIL wrap_w1: got %h want %h", g, {1'b0, 1'b1, 9'h000, 9'h1A4}); end
    tick();
    vec_cnt++;
    if ({done, busy} !== 2'b10) begin miss_cnt++; $display("FAIL wrap_done: got %b want 10", {done, busy}); end
    tick();
  endtask

  task automatic test_abort();
    logic [19:0] g;
    logic [2:0]  s;
    begin_session(9'h050, 9'd4);
    send(4'b1101, 5'd0, 5'd1); tick();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b0, 1'b1, 9'h050, 9'h1A1}) begin miss_cnt++; $display("FAIL abort_w0: got %h want %h", g, {1'b0, 1'b1, 9'h050, 9'h1A1}); end
    send(4'b1101, 5'd0, 5'd2);
    abort = 1'b1;
    #1;
    vec_cnt++;
    if (bus.req_ready !== 1'b0) begin miss_cnt++; $display("FAIL abort_ready: got %b want 0", bus.req_ready); end
    tick();
    abort = 1'b0;
    quiet();
    g = {done, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== {1'b1, 1'b0, 9'h050, 9'h1A1} || busy !== 1'b0) begin
      miss_cnt++; $display("FAIL abort_done: got %h busy %b want %h busy 0", g, busy, {1'b1, 1'b0, 9'h050, 9'h1A1});
    end
    tick();
    s = {done, busy, bus.im_we};
    vec_cnt++;
    if (s !== 3'b000) begin miss_cnt++; $display("FAIL abort_idle: got %b want 000", s); end
  endtask

  task automatic test_reset_mid();
    logic [30:0] g;
    logic [2:0]  s;
    begin_session(9'h060, 9'd4);
    send(4'b1101, 5'd0, 5'd1); tick();
    vec_cnt++;
    if (bus.im_we !== 1'b1) begin miss_cnt++; $display("FAIL rstmid_pending: got %b want 1", bus.im_we); end
    Reset_n = 1'b0;
    #1;
    g = {busy, done, err, err_cnt, bus.req_ready, bus.im_we, bus.im_addr, bus.im_wdata};
    vec_cnt++;
    if (g !== 31'd0) begin miss_cnt++; $display("FAIL rstmid_outputs: got %h want 0", g); end
    tick();
    Reset_n = 1'b1;
    tick(); tick();
    quiet();
    s = {busy, done, bus.im_we};
    vec_cnt++;
    if (s !== 3'b000) begin miss_cnt++; $display("FAIL rstmid_after: got %b want 000", s); end
  endtask

  initial begin
    Reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = 9'h0; length = 9'h0;
    quiet();
    test_reset();
    test_len0();
    test_basic();
    test_ldshift();
    test_illegal();
    test_range();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end

endmodule
